// File: rtl/apb_regfile_slave.sv
// APB completer: NUM_REGS RW scratch registers plus a read-only XFER_CNT.
// Define APB_SLV_WAIT_EN to stretch every transfer by WAIT_CYCLES access cycles.
module apb_regfile_slave #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  hclk,
    input  logic                  hreset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int unsigned CW =
        (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_WIDTH-1:0] CNT_IDX = ADDR_WIDTH'(NUM_REGS);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  hit_reg;
    logic                  hit_cnt;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] xfer_cnt;
    logic [DATA_WIDTH-1:0] rdata;

    // Addresses below BASE_ADDR wrap to a huge offset and fall into error.
    assign off     = paddr - BASE_ADDR;
    assign idx     = {2'b00, off[ADDR_WIDTH-1:2]};
    assign hit_reg = (off[1:0] == 2'b00) && (idx < CNT_IDX);
    assign hit_cnt = (off[1:0] == 2'b00) && (idx == CNT_IDX);

    always_comb begin
        rdata = xfer_cnt;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx == ADDR_WIDTH'(i)) begin
                rdata = regs[i];
            end
        end
    end

    assign done    = (state == ACCESS) && psel && penable && (cnt == '0);
    assign err     = !(hit_reg || (hit_cnt && !pwrite));
    assign pready  = done;
    assign pslverr = done && err;
    assign prdata  = (done && !err && !pwrite) ? rdata : '0;

`ifdef APB_SLV_WAIT_EN
    logic [CW-1:0] cnt_nxt;
`endif

    always_comb begin
        state_nxt = state;
`ifdef APB_SLV_WAIT_EN
        cnt_nxt = cnt;
`endif
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt = ACCESS;
`ifdef APB_SLV_WAIT_EN
                    cnt_nxt = CW'(WAIT_CYCLES);
`endif
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_nxt = IDLE;
                end else if (penable) begin
                    if (cnt != '0) begin
`ifdef APB_SLV_WAIT_EN
                        cnt_nxt = cnt - CW'(1);
`endif
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef APB_SLV_WAIT_EN
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end
`else
    assign cnt = '0;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (done && pwrite && hit_reg) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (idx == ADDR_WIDTH'(i)) begin
                    regs[i] <= pwdata;
                end
            end
        end
    end

    // Counts every completed transfer, error responses included.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            xfer_cnt <= '0;
        end else if (done) begin
            xfer_cnt <= xfer_cnt + DATA_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench for apb_regfile_slave; follows APB_SLV_WAIT_EN for wait length.
module tb_apb_regfile_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;
`ifdef APB_SLV_WAIT_EN
    localparam int EXPW = 2;
`else
    localparam int EXPW = 0;
`endif

    logic        hclk;
    logic        hreset;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int checks = 0;
    int errors = 0;

    apb_regfile_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (8),
        .BASE_ADDR  (BASE),
        .WAIT_CYCLES(2)
    ) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .psel   (psel),
        .penable(penable),
        .pwrite (pwrite),
        .paddr  (paddr),
        .pwdata (pwdata),
        .prdata (prdata),
        .pready (pready),
        .pslverr(pslverr)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic outs_zero(input string tag);
        check({tag, ".pready"}, {31'd0, pready}, 32'd0);
        check({tag, ".pslverr"}, {31'd0, pslverr}, 32'd0);
        check({tag, ".prdata"}, prdata, 32'd0);
    endtask

    task automatic xfer(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err, input string tag);
        @(posedge hclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = d;
        check({tag, ".setup_pready"}, {31'd0, pready}, 32'd0);
        @(posedge hclk);
        #1;
        penable = 1'b1;
        for (int i = 0; i < EXPW; i++) begin
            #1;
            check({tag, ".wait_pready"}, {31'd0, pready}, 32'd0);
            @(posedge hclk);
            #1;
        end
        #1;
        check({tag, ".pready"}, {31'd0, pready}, 32'd1);
        check({tag, ".pslverr"}, {31'd0, pslverr}, {31'd0, exp_err});
        check({tag, ".prdata"}, prdata, exp_rd);
    endtask

    task automatic bus_idle();
        @(posedge hclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        hreset  = 1'b1;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        #3;
        outs_zero("reset");
        #9;
        hreset = 1'b0;

        xfer(1'b0, BASE + 32'h20, 0, 32'd0, 1'b0, "xcnt_first");
        xfer(1'b0, BASE + 32'h20, 0, 32'd1, 1'b0, "xcnt_second");
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, BASE + 32'(4 * i), 0, 32'd0, 1'b0,
                 $sformatf("rst_reg%0d", i));
        end
        bus_idle();

        xfer(1'b1, BASE + 32'h04, 32'hDEAD_BEEF, 32'd0, 1'b0, "wr_r1");
        xfer(1'b0, BASE + 32'h04, 0, 32'hDEAD_BEEF, 1'b0, "rd_r1");
        xfer(1'b0, BASE + 32'h00, 0, 32'd0, 1'b0, "rd_r0");
        xfer(1'b0, BASE + 32'h08, 0, 32'd0, 1'b0, "rd_r2");
        bus_idle();

        xfer(1'b1, BASE + 32'h20, 32'h55, 32'd0, 1'b1, "wr_xcnt");
        xfer(1'b0, BASE + 32'h24, 0, 32'd0, 1'b1, "rd_oor");
        xfer(1'b0, BASE + 32'h02, 0, 32'd0, 1'b1, "rd_misal");
        xfer(1'b0, BASE - 32'h4, 0, 32'd0, 1'b1, "rd_below");
        xfer(1'b0, BASE + 32'h20, 0, 32'd18, 1'b0, "xcnt_after_err");
        xfer(1'b0, BASE + 32'h04, 0, 32'hDEAD_BEEF, 1'b0, "r1_kept");
        bus_idle();

        @(posedge hclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = BASE + 32'h08;
        pwdata  = 32'h1234;
        @(posedge hclk);
        #1;
        psel    = 1'b0;
        #1;
        outs_zero("abort");
        xfer(1'b0, BASE + 32'h08, 0, 32'd0, 1'b0, "abort_r2");
        xfer(1'b0, BASE + 32'h20, 0, 32'd21, 1'b0, "abort_xcnt");
        bus_idle();

        @(posedge hclk);
        #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = BASE + 32'h0C;
        pwdata  = 32'hAAAA_5555;
        @(posedge hclk);
        #1;
        penable = 1'b1;
        #2;
        hreset = 1'b1;
        #1;
        outs_zero("midrst");
        @(posedge hclk);
        #1;
        psel    = 1'b0;
        penable = 1'b0;
        hreset  = 1'b0;
        xfer(1'b0, BASE + 32'h0C, 0, 32'd0, 1'b0, "rst_r3");
        xfer(1'b0, BASE + 32'h04, 0, 32'd0, 1'b0, "rst_r1");
        xfer(1'b0, BASE + 32'h20, 0, 32'd2, 1'b0, "rst_xcnt");
        bus_idle();

        @(posedge hclk);
        #1;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = BASE + 32'h10;
        pwdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 3; i++) begin
            #1;
            outs_zero($sformatf("nosetup%0d", i));
            @(posedge hclk);
            #1;
        end
        psel    = 1'b0;
        penable = 1'b0;
        xfer(1'b0, BASE + 32'h10, 0, 32'd0, 1'b0, "nosetup_r4");
        xfer(1'b0, BASE + 32'h20, 0, 32'd4, 1'b0, "nosetup_xcnt");

        xfer(1'b1, BASE + 32'h08, 32'h1111_2222, 32'd0, 1'b0, "b2b_w2");
        xfer(1'b0, BASE + 32'h08, 0, 32'h1111_2222, 1'b0, "b2b_r2");
        xfer(1'b1, BASE + 32'h1C, 32'hCAFE_F00D, 32'd0, 1'b0, "b2b_w7");
        xfer(1'b0, BASE + 32'h1C, 0, 32'hCAFE_F00D, 1'b0, "b2b_r7");
        xfer(1'b1, BASE + 32'h00, 32'hFFFF_FFFF, 32'd0, 1'b0, "b2b_w0");
        xfer(1'b0, BASE + 32'h00, 0, 32'hFFFF_FFFF, 1'b0, "b2b_r0");
        xfer(1'b0, BASE + 32'h20, 0, 32'd11, 1'b0, "b2b_xcnt");
        bus_idle();
        #1;
        outs_zero("final_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer (slave) holding a small bank of read/write scratch registers plus a read-only transfer counter. Sits on the peripheral side of the AHB-to-APB bridge: it consumes psel/penable/pwrite/paddr/pwdata and returns prdata, pready and pslverr. Optional programmable wait states allow the bridge and bus fabric to be tested against a slow completer.

## Interface
- ADDR_WIDTH, 32, width of paddr
- DATA_WIDTH, 32, width of pwdata/prdata and of every register
- NUM_REGS, 8, number of RW scratch registers (1..255)
- BASE_ADDR, 32'h0000_0000, byte address of register index 0; must be word-aligned
- WAIT_CYCLES, 2, extra access cycles per transfer (used only with APB_SLV_WAIT_EN)

Ports:
- hclk  in  1  clock; all state changes on rising edge
- hreset  in  1  asynchronous, active-high reset
- psel  in  1  slave select
- penable  in  1  access phase strobe
- pwrite  in  1  1 = write, 0 = read
- paddr  in  ADDR_WIDTH  byte address
- pwdata  in  DATA_WIDTH  write data
- prdata  out  DATA_WIDTH  read data, valid only while pready=1
- pready  out  1  transfer completes this cycle
- pslverr  out  1  error response, valid only while pready=1

## Operation
- Decode: off = paddr - BASE_ADDR (ADDR_WIDTH-bit, wrap ignored); idx = off >> 2.
  - idx < NUM_REGS and off[1:0]==0: RW scratch register idx.
  - idx == NUM_REGS and off[1:0]==0: XFER_CNT, read-only.
  - Anything else (including paddr below BASE_ADDR, which wraps to a large off): error.
- FSM, two states:
  - IDLE: psel=1 & penable=0 (setup phase) -> ACCESS; wait counter loaded with WAIT_CYCLES. psel=1 & penable=1 (no setup) is a protocol violation: ignored, stay IDLE, pready stays 0.
  - ACCESS: psel=1 & penable=1 & cnt!=0 -> cnt-1, stay. psel=1 & penable=1 & cnt==0 -> complete, go IDLE. psel=0 -> abort, no commit, go IDLE.
- Completion cycle (pready=1):
  - Write to scratch reg: register <= pwdata at the rising edge closing the cycle; pslverr=0.
  - Read of scratch reg or XFER_CNT: prdata = its current value; pslverr=0.
  - Write to XFER_CNT or any access to an error address: no state change except XFER_CNT; pslverr=1; prdata=0.
- XFER_CNT: increments by 1 at every completed transfer, errors included; wraps all-ones -> 0. A read of XFER_CNT returns the pre-increment value.
- Address and control are sampled during the completion cycle; the master must hold them stable from setup to completion per APB.

## Timing
- Reset values: state IDLE, cnt 0, all scratch registers 0, XFER_CNT 0, prdata 0, pready 0, pslverr 0.
- pready, prdata and pslverr are combinational from state, cnt, psel, penable and decode. They are 0 outside the completion cycle.
- Transfer length: 1 setup cycle + (WAIT_CYCLES+1) access cycles with the macro, or 1 setup cycle + 1 access cycle without it.
- Back-to-back: a new setup phase may arrive in the cycle immediately after completion; no dead cycle is inserted.
- Reset asserted mid-transfer: transfer aborted, no write commit, no counter increment; outputs are 0 immediately (asynchronous).
- Read-after-write to the same register: the read in the next transfer returns the new value.

## Configuration
- APB_SLV_WAIT_EN defined: the wait counter is implemented and every transfer is stretched by WAIT_CYCLES access cycles with pready=0.
- APB_SLV_WAIT_EN undefined: the counter is removed and cnt is constant 0. pready asserts in the first access cycle and WAIT_CYCLES is ignored.

## Test plan
- Reset, then read idx 0..NUM_REGS-1 -> all prdata 0, pslverr 0. Read XFER_CNT (BASE+0x20) -> 0, and the next read of XFER_CNT returns 1.
- Write 0xDEAD_BEEF to BASE+0x04, then read BASE+0x04 -> 0xDEAD_BEEF with pslverr 0. Other registers remain 0.
- With APB_SLV_WAIT_EN and WAIT_CYCLES=2: single write -> pready low for 2 access cycles, high on the 3rd. Without the macro, pready is high on the 1st access cycle.
- Write to BASE+0x20 (XFER_CNT), read BASE+0x24, and read BASE+0x02 (misaligned) -> each gives pslverr=1 and prdata=0. XFER_CNT advances by 3 and no register changes.
- Deassert psel mid-ACCESS during a write of 0x1234 to BASE+0x08 -> register stays 0 and XFER_CNT is unchanged. Assert hreset during ACCESS -> all outputs are 0 at once and the FSM returns to IDLE.
- Issue psel=1 & penable=1 with no setup phase -> pready remains 0 and no state change. Follow with back-to-back write/read pairs with no idle cycle -> each completes with correct data.
